// File: rtl/l1d_evict_buf_if.sv
// Evict-beat ingress, write-back egress, credit/done return and error flags of l1d_evict_buf.
// master drives beats and downstream ready; slave is the buffer.
interface l1d_evict_buf_if #(
    parameter int DATA_WIDTH   = 256,
    parameter int TAG_WIDTH    = 20,
    parameter int INDEX_WIDTH  = 6,
    parameter int OFFSET_WIDTH = 1,
    parameter int ID_WIDTH     = 5
);
    logic                    in_vld;
    logic [TAG_WIDTH-1:0]    in_tag;
    logic [INDEX_WIDTH-1:0]  in_index;
    logic [OFFSET_WIDTH-1:0] in_offset;
    logic [DATA_WIDTH-1:0]   in_data;
    logic                    in_last;
    logic [ID_WIDTH-1:0]     in_evict_id;
    logic                    credit_ret;
    logic                    out_vld;
    logic                    out_rdy;
    logic [TAG_WIDTH-1:0]    out_tag;
    logic [INDEX_WIDTH-1:0]  out_index;
    logic [OFFSET_WIDTH-1:0] out_offset;
    logic [DATA_WIDTH-1:0]   out_data;
    logic                    out_last;
    logic [ID_WIDTH-1:0]     out_evict_id;
    logic                    done_vld;
    logic [ID_WIDTH-1:0]     done_id;
    logic                    err_overflow;
    logic                    err_protocol;

    modport master (
        output in_vld, in_tag, in_index, in_offset, in_data, in_last, in_evict_id, out_rdy,
        input  credit_ret, out_vld, out_tag, out_index, out_offset, out_data, out_last,
               out_evict_id, done_vld, done_id, err_overflow, err_protocol
    );

    modport slave (
        input  in_vld, in_tag, in_index, in_offset, in_data, in_last, in_evict_id, out_rdy,
        output credit_ret, out_vld, out_tag, out_index, out_offset, out_data, out_last,
               out_evict_id, done_vld, done_id, err_overflow, err_protocol
    );
endinterface

// File: rtl/l1d_evict_buf.sv
// Eviction data buffer: credit-governed beat FIFO between the L1D evict read pipe and the
// write-back channel, draining in store-and-forward or cut-through mode.
module l1d_evict_buf #(
    parameter int DATA_WIDTH   = 256,
    parameter int TAG_WIDTH    = 20,
    parameter int INDEX_WIDTH  = 6,
    parameter int OFFSET_WIDTH = 1,
    parameter int ID_WIDTH     = 5,
    parameter int LINE_NUM     = 2,
    parameter int CUT_THROUGH  = 0
) (
    input logic            clk,
    input logic            rst_n,
    l1d_evict_buf_if.slave bus
);
    localparam int BEATS = 1 << OFFSET_WIDTH;
    localparam int DEPTH = LINE_NUM * BEATS;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int ENT_W = TAG_WIDTH + INDEX_WIDTH + OFFSET_WIDTH + DATA_WIDTH + 1 + ID_WIDTH;

    logic [ENT_W-1:0]        mem [DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [CNT_W-1:0]        count;
    logic [CNT_W-1:0]        full_lines;
    logic [OFFSET_WIDTH-1:0] beat_cnt;
    logic [ENT_W-1:0]        head;
    logic                    head_last;
    logic [ID_WIDTH-1:0]     head_id;
    logic                    push;
    logic                    pop;
    logic                    out_vld_c;
    logic                    beat_final;
    logic                    line_inc;
    logic                    line_dec;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Fullness uses the occupancy before this cycle's pop, so a pop never frees a slot early.
    assign push       = bus.in_vld && (count != CNT_W'(DEPTH));
    assign beat_final = (beat_cnt == OFFSET_WIDTH'(BEATS - 1));
    assign head       = mem[rd_ptr];
    assign head_last  = head[ID_WIDTH];
    assign head_id    = head[ID_WIDTH-1:0];

    // full_lines counts stored last beats, so store-and-forward only drains complete lines.
    assign out_vld_c  = (count != '0) && ((CUT_THROUGH != 0) || (full_lines != '0));
    assign pop        = out_vld_c && bus.out_rdy;
    assign line_inc   = push && bus.in_last;
    assign line_dec   = pop && head_last;

    assign bus.out_vld = out_vld_c;
    assign {bus.out_tag, bus.out_index, bus.out_offset, bus.out_data,
            bus.out_last, bus.out_evict_id} = head;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {bus.in_tag, bus.in_index, bus.in_offset, bus.in_data,
                            bus.in_last, bus.in_evict_id};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            count            <= '0;
            full_lines       <= '0;
            beat_cnt         <= '0;
            bus.credit_ret   <= 1'b0;
            bus.done_vld     <= 1'b0;
            bus.done_id      <= '0;
            bus.err_overflow <= 1'b0;
            bus.err_protocol <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr   <= ptr_inc(wr_ptr);
                beat_cnt <= (bus.in_last || beat_final) ? '0 : beat_cnt + 1'b1;
                if (bus.in_last != beat_final) begin
                    bus.err_protocol <= 1'b1;
                end
            end
            if (bus.in_vld && !push) begin
                bus.err_overflow <= 1'b1;
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (!push && pop) begin
                count <= count - 1'b1;
            end
            if (line_inc && !line_dec) begin
                full_lines <= full_lines + 1'b1;
            end else if (!line_inc && line_dec) begin
                full_lines <= full_lines - 1'b1;
            end
            // Return path: one cycle after the handshake that freed the slot.
            bus.credit_ret <= pop;
            bus.done_vld   <= line_dec;
            if (line_dec) begin
                bus.done_id <= head_id;
            end
        end
    end
endmodule

// File: tb/tb_l1d_evict_buf.sv
// Bench for l1d_evict_buf: three instances (SF DEPTH 4, CT DEPTH 4, SF DEPTH 6) share one
// stimulus stream and are checked every cycle against a queue model plus literal expectations.
module tb_l1d_evict_buf;
    localparam int DW   = 32;
    localparam int TW   = 8;
    localparam int IW   = 4;
    localparam int OW   = 1;
    localparam int IDW  = 5;
    localparam int NB   = 1 << OW;
    localparam int NDUT = 3;

    typedef struct packed {
        logic [TW-1:0]  tag;
        logic [IW-1:0]  idx;
        logic [OW-1:0]  off;
        logic [DW-1:0]  data;
        logic           last;
        logic [IDW-1:0] id;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic in_vld = 1'b0;
    logic [TW-1:0] in_tag = '0;
    logic [IW-1:0] in_index = '0;
    logic [OW-1:0] in_offset = '0;
    logic [DW-1:0] in_data = '0;
    logic in_last = 1'b0;
    logic [IDW-1:0] in_evict_id = '0;
    logic out_rdy = 1'b0;

    logic           o_vld [NDUT];
    logic           o_cr [NDUT];
    logic           o_done [NDUT];
    logic           o_eovf [NDUT];
    logic           o_eprot [NDUT];
    logic           o_last [NDUT];
    logic [TW-1:0]  o_tag [NDUT];
    logic [IW-1:0]  o_idx [NDUT];
    logic [OW-1:0]  o_off [NDUT];
    logic [DW-1:0]  o_data [NDUT];
    logic [IDW-1:0] o_id [NDUT];
    logic [IDW-1:0] o_did [NDUT];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : u
        l1d_evict_buf_if #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .INDEX_WIDTH(IW),
                           .OFFSET_WIDTH(OW), .ID_WIDTH(IDW)) bus ();
        assign bus.in_vld      = in_vld;
        assign bus.in_tag      = in_tag;
        assign bus.in_index    = in_index;
        assign bus.in_offset   = in_offset;
        assign bus.in_data     = in_data;
        assign bus.in_last     = in_last;
        assign bus.in_evict_id = in_evict_id;
        assign bus.out_rdy     = out_rdy;
        assign o_vld[g]   = bus.out_vld;
        assign o_cr[g]    = bus.credit_ret;
        assign o_done[g]  = bus.done_vld;
        assign o_eovf[g]  = bus.err_overflow;
        assign o_eprot[g] = bus.err_protocol;
        assign o_last[g]  = bus.out_last;
        assign o_tag[g]   = bus.out_tag;
        assign o_idx[g]   = bus.out_index;
        assign o_off[g]   = bus.out_offset;
        assign o_data[g]  = bus.out_data;
        assign o_id[g]    = bus.out_evict_id;
        assign o_did[g]   = bus.done_id;

        l1d_evict_buf #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .INDEX_WIDTH(IW), .OFFSET_WIDTH(OW),
                        .ID_WIDTH(IDW), .LINE_NUM((g == 2) ? 3 : 2),
                        .CUT_THROUGH((g == 1) ? 1 : 0)) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );
    end

    int errors = 0;
    int checks = 0;
    beat_t mq [NDUT][$];
    int bc [NDUT];
    bit m_eovf [NDUT];
    bit m_eprot [NDUT];
    bit m_cr [NDUT];
    bit m_done [NDUT];
    logic [IDW-1:0] m_did [NDUT];
    int cr_cnt [NDUT];
    int dn_cnt [NDUT];
    int credit;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endfunction

    function automatic int depth_of(input int d);
        return ((d == 2) ? 3 : 2) * NB;
    endfunction

    function automatic int lines_in(input int d);
        int n = 0;
        for (int i = 0; i < mq[d].size(); i++) if (mq[d][i].last) n++;
        return n;
    endfunction

    function automatic bit exp_vld(input int d);
        return (mq[d].size() > 0) && ((d == 1) || (lines_in(d) > 0));
    endfunction

    task automatic model_reset();
        for (int d = 0; d < NDUT; d++) begin
            mq[d].delete();
            bc[d] = 0; m_eovf[d] = 0; m_eprot[d] = 0;
            m_cr[d] = 0; m_done[d] = 0; m_did[d] = '0;
        end
    endtask

    // Apply one clock edge of the spec's rules to each model, using the inputs now on the pins.
    task automatic model_edge();
        for (int d = 0; d < NDUT; d++) begin
            bit pop, push;
            beat_t b;
            pop  = exp_vld(d) && out_rdy;
            push = in_vld && (mq[d].size() < depth_of(d));
            m_cr[d]   = pop;
            m_done[d] = pop && mq[d][0].last;
            if (m_done[d]) m_did[d] = mq[d][0].id;
            if (in_vld && !push) m_eovf[d] = 1;
            if (push) begin
                if (in_last != (bc[d] == NB - 1)) m_eprot[d] = 1;
                bc[d] = (in_last || bc[d] == NB - 1) ? 0 : bc[d] + 1;
                b = '{tag: in_tag, idx: in_index, off: in_offset, data: in_data,
                      last: in_last, id: in_evict_id};
            end
            if (pop) void'(mq[d].pop_front());
            if (push) mq[d].push_back(b);
        end
    endtask

    task automatic compare();
        for (int d = 0; d < NDUT; d++) begin
            chk($sformatf("d%0d out_vld", d), 64'(o_vld[d]), 64'(exp_vld(d)));
            if (exp_vld(d))
                chk($sformatf("d%0d head beat", d),
                    64'({o_tag[d], o_idx[d], o_off[d], o_data[d], o_last[d], o_id[d]}),
                    64'(mq[d][0]));
            chk($sformatf("d%0d credit_ret", d), 64'(o_cr[d]), 64'(m_cr[d]));
            chk($sformatf("d%0d done_vld", d), 64'(o_done[d]), 64'(m_done[d]));
            if (m_done[d]) chk($sformatf("d%0d done_id", d), 64'(o_did[d]), 64'(m_did[d]));
            chk($sformatf("d%0d err_overflow", d), 64'(o_eovf[d]), 64'(m_eovf[d]));
            chk($sformatf("d%0d err_protocol", d), 64'(o_eprot[d]), 64'(m_eprot[d]));
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        compare();
        for (int d = 0; d < NDUT; d++) begin
            if (o_cr[d]) cr_cnt[d]++;
            if (o_done[d]) dn_cnt[d]++;
        end
        if (o_cr[2]) credit++;
    endtask

    task automatic clear_cnt();
        for (int d = 0; d < NDUT; d++) begin
            cr_cnt[d] = 0;
            dn_cnt[d] = 0;
        end
    endtask

    task automatic set_beat(input logic [TW-1:0] tag, input logic [IW-1:0] idx,
                            input logic [OW-1:0] off, input logic [DW-1:0] data,
                            input logic last, input logic [IDW-1:0] id);
        in_vld = 1'b1; in_tag = tag; in_index = idx; in_offset = off;
        in_data = data; in_last = last; in_evict_id = id;
    endtask

    task automatic idle();
        in_vld = 1'b0;
        in_last = 1'b0;
    endtask

    // Called just after a clock edge: asserts reset mid-cycle and checks outputs fall at once.
    task automatic do_reset(input string nm);
        idle();
        #3;
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < NDUT; d++) begin
            chk($sformatf("%s d%0d out_vld", nm, d), 64'(o_vld[d]), 64'd0);
            chk($sformatf("%s d%0d credit_ret", nm, d), 64'(o_cr[d]), 64'd0);
            chk($sformatf("%s d%0d done_vld", nm, d), 64'(o_done[d]), 64'd0);
            chk($sformatf("%s d%0d done_id", nm, d), 64'(o_did[d]), 64'd0);
            chk($sformatf("%s d%0d err_overflow", nm, d), 64'(o_eovf[d]), 64'd0);
            chk($sformatf("%s d%0d err_protocol", nm, d), 64'(o_eprot[d]), 64'd0);
        end
        model_reset();
        credit = NB * 3;
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        clear_cnt();
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset("reset");

        // Two-beat line A, downstream always ready.
        out_rdy = 1'b1;
        clear_cnt();
        set_beat(8'h5A, 4'h3, 1'b0, 32'hA000_0000, 1'b0, 5'd7);
        step();
        chk("A T1 sf out_vld", 64'(o_vld[0]), 64'd0);
        chk("A T1 ct out_vld", 64'(o_vld[1]), 64'd1);
        chk("A T1 ct out_data", 64'(o_data[1]), 64'hA000_0000);
        set_beat(8'h5A, 4'h3, 1'b1, 32'hA000_0001, 1'b1, 5'd7);
        step();
        idle();
        chk("A T2 sf out_vld", 64'(o_vld[0]), 64'd1);
        chk("A T2 sf out_data", 64'(o_data[0]), 64'hA000_0000);
        chk("A T2 ct out_data", 64'(o_data[1]), 64'hA000_0001);
        chk("A T2 ct credit_ret", 64'(o_cr[1]), 64'd1);
        step();
        chk("A T3 sf out_data", 64'(o_data[0]), 64'hA000_0001);
        chk("A T3 sf credit_ret", 64'(o_cr[0]), 64'd1);
        chk("A T3 sf done_vld", 64'(o_done[0]), 64'd0);
        chk("A T3 ct done_vld", 64'(o_done[1]), 64'd1);
        chk("A T3 ct done_id", 64'(o_did[1]), 64'd7);
        step();
        chk("A T4 sf credit_ret", 64'(o_cr[0]), 64'd1);
        chk("A T4 sf done_vld", 64'(o_done[0]), 64'd1);
        chk("A T4 sf done_id", 64'(o_did[0]), 64'd7);
        chk("A T4 sf out_vld", 64'(o_vld[0]), 64'd0);
        step();
        chk("A credits sf", 64'(cr_cnt[0]), 64'd2);
        chk("A credits ct", 64'(cr_cnt[1]), 64'd2);

        // Fill with downstream stalled: DEPTH-4 instances drop beats 5 and 6.
        out_rdy = 1'b0;
        clear_cnt();
        for (int i = 0; i < 6; i++) begin
            set_beat(TW'(8'h10 + i / 2), IW'(i / 2), OW'(i % 2), DW'(32'hB000_0000 + i),
                     (i % 2) == 1, IDW'(1 + i / 2));
            step();
        end
        idle();
        step();
        chk("fill sf err_overflow", 64'(o_eovf[0]), 64'd1);
        chk("fill ct err_overflow", 64'(o_eovf[1]), 64'd1);
        chk("fill depth6 err_overflow", 64'(o_eovf[2]), 64'd0);
        out_rdy = 1'b1;
        repeat (10) step();
        chk("fill sf credits", 64'(cr_cnt[0]), 64'd4);
        chk("fill ct credits", 64'(cr_cnt[1]), 64'd4);
        chk("fill sf done count", 64'(dn_cnt[0]), 64'd2);
        chk("fill depth6 credits", 64'(cr_cnt[2]), 64'd6);
        chk("fill depth6 done count", 64'(dn_cnt[2]), 64'd3);
        do_reset("rst2");

        // Ten lines through the DEPTH-6 instance under credit flow and random stalls.
        clear_cnt();
        for (int l = 0; l < 10; l++) begin
            for (int b = 0; b < NB; b++) begin
                int wait_cyc = 0;
                while (credit == 0 && wait_cyc < 200) begin
                    idle();
                    out_rdy = ($urandom_range(3) != 0);
                    step();
                    wait_cyc++;
                end
                set_beat(TW'(8'h40 + l), IW'(l), OW'(b), $urandom, b == NB - 1, IDW'(l + 3));
                out_rdy = ($urandom_range(3) != 0);
                credit--;
                step();
            end
        end
        idle();
        for (int n = 0; n < 300 && dn_cnt[2] < 10; n++) begin
            out_rdy = ($urandom_range(3) != 0);
            step();
        end
        chk("wrap credits", 64'(cr_cnt[2]), 64'd20);
        chk("wrap done count", 64'(dn_cnt[2]), 64'd10);
        chk("wrap credit pool", 64'(credit), 64'd6);
        chk("wrap err_overflow", 64'(o_eovf[2]), 64'd0);
        chk("wrap err_protocol", 64'(o_eprot[2]), 64'd0);
        do_reset("rst3");

        // Single-beat line marked last, then a normal line.
        out_rdy = 1'b1;
        clear_cnt();
        set_beat(8'h77, 4'h9, 1'b0, 32'hC0DE_0000, 1'b1, 5'd9);
        step();
        idle();
        chk("proto err_protocol sf", 64'(o_eprot[0]), 64'd1);
        chk("proto ct out_data", 64'(o_data[1]), 64'hC0DE_0000);
        for (int b = 0; b < NB; b++) begin
            set_beat(8'h78, 4'hA, OW'(b), DW'(32'hD000_0000 + b), b == NB - 1, 5'd10);
            step();
        end
        idle();
        repeat (4) step();
        chk("proto sf done count", 64'(dn_cnt[0]), 64'd2);
        chk("proto sf credits", 64'(cr_cnt[0]), 64'd3);
        chk("proto sf last done_id", 64'(o_did[0]), 64'd10);

        // Three beats held, then reset mid-cycle with a sticky error still set.
        out_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_beat(8'h90, 4'h1, OW'(i % 2), DW'(32'hE000_0000 + i), (i % 2) == 1, 5'd12);
            step();
        end
        do_reset("midline");
        out_rdy = 1'b1;
        clear_cnt();
        for (int b = 0; b < NB; b++) begin
            set_beat(8'h91, 4'h2, OW'(b), DW'(32'hF000_0000 + b), b == NB - 1, 5'd13);
            step();
        end
        idle();
        repeat (4) step();
        chk("fresh sf done count", 64'(dn_cnt[0]), 64'd1);
        chk("fresh sf done_id", 64'(o_did[0]), 64'd13);
        chk("fresh depth6 credits", 64'(cr_cnt[2]), 64'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
